// File: rtl/fetch_queue.sv
// Fetch stage: PC generator feeding a DEPTH-entry instruction prefetch queue.
// Optional perf counters (fetch_cnt, flush_cnt) under `FETCH_PERF_EN.
module fetch_queue #(
  parameter logic [31:0] PC_INIT = 32'h0,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
)(
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic [31:0]      imemload,
  output logic             imemREN,
  output logic [31:0]      imemaddr,
  input  logic             halt,
  input  logic             redirect,
  input  logic [1:0]       PCSrc,
  input  logic [31:0]      brPC,
  input  logic [15:0]      imm,
  input  logic [31:0]      jraddr,
  input  logic [31:0]      jPC,
  input  logic [25:0]      jaddr,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [31:0]      instr,
  output logic [31:0]      pc,
  output logic [31:0]      npc,
  output logic [CNT_W-1:0] count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      fetch_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]   fpc;
  logic [31:0]   target;
  logic [31:0]   br_off;
  logic [31:0]   iq [DEPTH];
  logic [31:0]   pq [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          push;
  logic          pop;
  logic          unused_jpc;

  assign unused_jpc = ^jPC[27:0];

  assign imemaddr  = fpc;
  assign imemREN   = ~RST & ~halt & ~redirect & (count < FULL);
  assign push      = imemREN & ihit;
  assign deq_valid = (count != '0);
  assign pop       = deq_valid & deq_ready & ~redirect;

  assign br_off = {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    target = brPC;
    unique case (PCSrc)
      2'd0: target = brPC;
      2'd1: target = jraddr;
      2'd2: target = {jPC[31:28], jaddr, 2'b00};
      2'd3: target = brPC + br_off;
    endcase
  end

  assign instr = deq_valid ? iq[head] : '0;
  assign pc    = deq_valid ? pq[head] : '0;
  assign npc   = deq_valid ? pq[head] + 32'd4 : '0;

  // Redirect wins over everything: any same-cycle push or pop is dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fpc   <= PC_INIT;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      fpc   <= target;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fpc  <= fpc + 32'd4;
        tail <= tail + AW'(1);
      end
      if (pop)
        head <= head + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      iq[tail] <= imemload;
      pq[tail] <= fpc;
    end
  end

`ifdef FETCH_PERF_EN
  logic [32:0] flush_sum;

  assign flush_sum = {1'b0, flush_cnt} + 33'(count);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push && fetch_cnt != '1)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect)
        flush_cnt <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: per-cycle vector table plus a pop scoreboard.
// Also covers async reset mid-cycle and, if enabled, the perf counters.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic             CLK, RST, ihit, imemREN, halt, redirect;
  logic [31:0]      imemload, imemaddr, brPC, jraddr, jPC;
  logic [31:0]      instr, pc, npc;
  logic [1:0]       PCSrc;
  logic [15:0]      imm;
  logic [25:0]      jaddr;
  logic             deq_valid, deq_ready;
  logic [CNT_W-1:0] count;
`ifdef FETCH_PERF_EN
  logic [31:0]      fetch_cnt, flush_cnt;
`endif

  fetch_queue #(.PC_INIT(32'h0), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .halt(halt),
    .redirect(redirect), .PCSrc(PCSrc), .brPC(brPC), .imm(imm),
    .jraddr(jraddr), .jPC(jPC), .jaddr(jaddr),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .instr(instr), .pc(pc), .npc(npc), .count(count)
`ifdef FETCH_PERF_EN
    , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] ld(input logic [31:0] a);
    return 32'hDEAD_0000 ^ {a[7:0], a[31:8]};
  endfunction

  assign imemload = ld(imemaddr);

  typedef struct {
    logic        ih, rdy, hl, rd;
    logic [1:0]  src;
    logic [31:0] br;
    logic [15:0] im;
    logic [31:0] jr, jp;
    logic [25:0] ja;
    logic        ren;
    int          cnt;
    logic [31:0] addr;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] a;
  } ent_t;

  vec_t vt[$];
  ent_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   exp_fetch = 0;
  int   exp_flush = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic n(input logic ih, rdy, hl, ren, input int c,
                   input logic [31:0] a);
    vec_t v;
    v = '{ih, rdy, hl, 1'b0, 2'd0, 32'h0, 16'h0, 32'h0, 32'h0,
          26'h0, ren, c, a};
    vt.push_back(v);
  endtask

  task automatic r(input logic [1:0] s, input logic [31:0] b,
                   input logic [15:0] im, input logic [31:0] jr, jp,
                   input logic [25:0] ja, input logic ih, rdy, hl,
                   input logic [31:0] a);
    vec_t v;
    v = '{ih, rdy, hl, 1'b1, s, b, im, jr, jp, ja, 1'b0, 0, a};
    vt.push_back(v);
  endtask

  initial begin
    logic [31:0] cur;
    ent_t e;
    RST = 1'b1; ihit = 0; halt = 0; redirect = 0; PCSrc = 0;
    brPC = 0; imm = 0; jraddr = 0; jPC = 0; jaddr = 0; deq_ready = 0;

    // fill queue, then full
    n(1,0,0,1,1,32'h4);  n(1,0,0,1,2,32'h8);
    n(1,0,0,1,3,32'hC);  n(1,0,0,1,4,32'h10);
    n(1,0,0,0,4,32'h10);
    // drain
    n(0,1,0,0,3,32'h10); n(0,1,0,1,2,32'h10);
    n(0,1,0,1,1,32'h10); n(0,1,0,1,0,32'h10);
    n(0,1,0,1,0,32'h10);
    // wait states
    n(0,0,0,1,0,32'h10); n(0,0,0,1,0,32'h10);
    n(1,0,0,1,1,32'h14);
    n(0,0,0,1,1,32'h14); n(0,0,0,1,1,32'h14); n(0,0,0,1,1,32'h14);
    n(1,0,0,1,2,32'h18);
    n(1,1,0,1,2,32'h1C);
    n(1,0,0,1,3,32'h20);
    // branch back: 0x10 - 4
    r(2'd3,32'h10,16'hFFFF,0,0,0, 1,1,0, 32'hC);
    n(1,0,0,1,1,32'h10);
    r(2'd2,0,0,0,32'hA000_0000,26'h40, 1,0,0, 32'hA000_0100);
    r(2'd1,0,0,32'h400,0,0, 1,0,0, 32'h400);
    n(1,0,0,1,1,32'h404);
    r(2'd0,32'h1234_5678,0,0,0,0, 0,1,0, 32'h1234_5678);
    // halt freezes fetch
    n(1,0,1,0,0,32'h1234_5678); n(0,1,1,0,0,32'h1234_5678);
    n(1,0,0,1,1,32'h1234_567C);
    // address wrap
    r(2'd0,32'hFFFF_FFFC,0,0,0,0, 1,0,0, 32'hFFFF_FFFC);
    n(1,0,0,1,1,32'h0);  n(1,1,0,1,1,32'h4);
    // redirect beats halt
    r(2'd1,0,0,32'h80,0,0, 0,0,1, 32'h80);
    n(1,0,0,1,1,32'h84); n(1,0,0,1,2,32'h88);
    n(0,1,1,0,1,32'h88); n(0,0,1,0,1,32'h88);

    @(negedge CLK); #1;
    chk("rst imemREN", imemREN, 1'b0);
    chk("rst count", 32'(count), 0);
    chk("rst deq_valid", deq_valid, 1'b0);
    chk("rst imemaddr", imemaddr, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    cur = 32'h0;

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge CLK);
      ihit = vt[i].ih; deq_ready = vt[i].rdy; halt = vt[i].hl;
      redirect = vt[i].rd; PCSrc = vt[i].src; brPC = vt[i].br;
      imm = vt[i].im; jraddr = vt[i].jr; jPC = vt[i].jp;
      jaddr = vt[i].ja;
      #1;
      chk($sformatf("v%0d imemREN", i), imemREN, vt[i].ren);
      chk($sformatf("v%0d deq_valid", i), deq_valid, sb.size() != 0);
      if (vt[i].rd) begin
        exp_flush += sb.size();
        sb.delete();
      end else begin
        if (vt[i].rdy && sb.size() != 0) begin
          e = sb.pop_front();
          chk($sformatf("v%0d instr", i), instr, e.ins);
          chk($sformatf("v%0d pc", i), pc, e.a);
          chk($sformatf("v%0d npc", i), npc, e.a + 32'd4);
        end
        if (vt[i].ih && vt[i].ren) begin
          e.ins = ld(cur); e.a = cur;
          sb.push_back(e);
          exp_fetch++;
        end
      end
      @(posedge CLK); #1;
      chk($sformatf("v%0d count", i), 32'(count), vt[i].cnt);
      chk($sformatf("v%0d imemaddr", i), imemaddr, vt[i].addr);
      cur = vt[i].addr;
    end

    redirect = 0; deq_ready = 0;
`ifdef FETCH_PERF_EN
    chk("fetch_cnt", fetch_cnt, exp_fetch);
    chk("flush_cnt", flush_cnt, exp_flush);
`endif

    // halt with request pending, then async reset mid-cycle
    @(negedge CLK);
    halt = 1'b1; ihit = 1'b0;
    #3 RST = 1'b1;
    #1;
    chk("async imemREN", imemREN, 1'b0);
    chk("async count", 32'(count), 0);
    chk("async deq_valid", deq_valid, 1'b0);
    chk("async imemaddr", imemaddr, 32'h0);
    chk("async instr", instr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("async fetch_cnt", fetch_cnt, 0);
    chk("async flush_cnt", flush_cnt, 0);
`endif
    @(negedge CLK);
    RST = 1'b0; halt = 1'b0;
    #1;
    chk("resume imemREN", imemREN, 1'b1);
    chk("resume imemaddr", imemaddr, 32'h0);
    ihit = 1'b1;
    @(posedge CLK); #1;
    ihit = 1'b0;
    chk("resume count", 32'(count), 1);
    chk("resume pc", pc, 32'h0);
    chk("resume instr", instr, ld(32'h0));
    chk("resume imemaddr2", imemaddr, 32'h4);
`ifdef FETCH_PERF_EN
    chk("resume fetch_cnt", fetch_cnt, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
